// File: rtl/decode_queue_unit_if.sv
// Handshake bundle for decode_queue_unit.
//  Fetch side : in_valid/in_ready/instr/pc plus the flush redirect.
//  Execute side: out_valid/out_ready and the decoded control fields of the
//                head entry, plus the sticky halt flag and retired counter.
//  master: the environment (fetch latch + execute stage).
//  slave : the decode queue itself.
interface decode_queue_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_wsel;
    logic [4:0]        out_shamt;
    logic [31:0]       out_imm;
    logic [3:0]        out_aluctr;
    logic [1:0]        out_alusrc;
    logic              out_regwr;
    logic [1:0]        out_memtoreg;
    logic              out_dren;
    logic              out_dwen;
    logic              out_atomic;
    logic [1:0]        out_pcsrc;
    logic              out_halt;
    logic              halt;
    logic [CNT_W-1:0]  retired;

    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_wsel,
               out_shamt, out_imm, out_aluctr, out_alusrc, out_regwr,
               out_memtoreg, out_dren, out_dwen, out_atomic, out_pcsrc,
               out_halt, halt, retired
    );

    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_wsel,
               out_shamt, out_imm, out_aluctr, out_alusrc, out_regwr,
               out_memtoreg, out_dren, out_dwen, out_atomic, out_pcsrc,
               out_halt, halt, retired
    );
endinterface

// File: rtl/decode_queue_unit.sv
// decode_queue_unit
//  Decodes fetched MIPS words into the full control bundle and buffers the
//  results in a DEPTH-entry FIFO between fetch and execute. Adds flush,
//  a sticky halt flag and a retired-instruction counter.
// Ports
//  CLK  : clock, all state on posedge
//  RST  : synchronous active-high reset
//  bus  : decode_queue_unit_if.slave (fetch handshake, head-entry fields,
//         flush, halt, retired)
// ALU encoding (aluop_t): SLL=0 SRL=1 ADD=2 SUB=3 AND=4 OR=5 XOR=6 NOR=7
//                         SLT=8 SLTU=9
// HALT is opcode 6'b111111.
module decode_queue_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input logic CLK,
    input logic RST,
    decode_queue_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        wsel;
        logic [4:0]        shamt;
        logic [31:0]       imm;
        logic [3:0]        aluctr;
        logic [1:0]        alusrc;
        logic              regwr;
        logic [1:0]        memtoreg;
        logic              dren;
        logic              dwen;
        logic              atomic;
        logic [1:0]        pcsrc;
        logic              is_halt;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] w,
                                      input logic [ADDR_W-1:0] p);
        entry_t     e;
        logic [5:0] op;
        logic [5:0] fn;
        op       = w[31:26];
        fn       = w[5:0];
        e        = '0;
        e.pc     = p;
        e.rs     = w[25:21];
        e.rt     = w[20:16];
        e.shamt  = w[10:6];
        e.wsel   = w[20:16];
        e.aluctr = ALU_ADD;
        e.imm    = {{16{w[15]}}, w[15:0]};
        case (op)
            OP_RTYPE: begin
                e.wsel  = w[15:11];
                e.regwr = 1'b1;
                case (fn)
                    FN_SLL:  e.aluctr = ALU_SLL;
                    FN_SRL:  e.aluctr = ALU_SRL;
                    FN_ADD,
                    FN_ADDU: e.aluctr = ALU_ADD;
                    FN_SUB,
                    FN_SUBU: e.aluctr = ALU_SUB;
                    FN_AND:  e.aluctr = ALU_AND;
                    FN_OR:   e.aluctr = ALU_OR;
                    FN_XOR:  e.aluctr = ALU_XOR;
                    FN_NOR:  e.aluctr = ALU_NOR;
                    FN_SLT:  e.aluctr = ALU_SLT;
                    FN_SLTU: e.aluctr = ALU_SLTU;
                    FN_JR: begin
                        e.regwr = 1'b0;
                        e.pcsrc = 2'd1;
                    end
                    default: e.regwr = 1'b0;
                endcase
            end
            OP_J:   e.pcsrc = 2'd2;
            OP_JAL: begin
                e.pcsrc    = 2'd2;
                e.wsel     = 5'd31;
                e.regwr    = 1'b1;
                e.memtoreg = 2'd2;
            end
            OP_BEQ, OP_BNE: begin
                e.pcsrc  = 2'd3;
                e.aluctr = ALU_SUB;
            end
            OP_ADDIU: begin
                e.alusrc = 2'd1;
                e.regwr  = 1'b1;
            end
            OP_SLTI: begin
                e.alusrc = 2'd1;
                e.regwr  = 1'b1;
                e.aluctr = ALU_SLT;
            end
            OP_SLTIU: begin
                e.alusrc = 2'd1;
                e.regwr  = 1'b1;
                e.aluctr = ALU_SLTU;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                e.alusrc = 2'd1;
                e.regwr  = 1'b1;
                e.imm    = {16'h0, w[15:0]};
                e.aluctr = (op == OP_ANDI) ? ALU_AND :
                           (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                e.alusrc = 2'd2;
                e.regwr  = 1'b1;
                e.imm    = {w[15:0], 16'h0};
            end
            OP_LW, OP_LL: begin
                e.alusrc   = 2'd1;
                e.regwr    = 1'b1;
                e.dren     = 1'b1;
                e.memtoreg = 2'd1;
                e.atomic   = (op == OP_LL);
            end
            OP_SW: begin
                e.alusrc = 2'd1;
                e.dwen   = 1'b1;
            end
            OP_SC: begin
                // SC writes its success flag back into rt from the memory side.
                e.alusrc   = 2'd1;
                e.regwr    = 1'b1;
                e.dwen     = 1'b1;
                e.memtoreg = 2'd1;
                e.atomic   = 1'b1;
            end
            OP_HALT: e.is_halt = 1'b1;
            default: ;
        endcase
        // The all-zero word is SLL $0,$0,0; never let it claim a write.
        if (w == 32'h0) e.regwr = 1'b0;
        return e;
    endfunction

    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             halt_seen;
    logic             halt_q;
    logic [CNT_W-1:0] retired_q;
    logic             push;
    logic             pop;

    assign dec   = decode(bus.instr, bus.pc);
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));

    // in_ready only looks at stored state, so a pop in the same cycle
    // does not free a slot until the next cycle.
    assign bus.in_ready  = !full && !halt_seen;
    assign bus.out_valid = !empty;

    // Flush wins over both handshakes.
    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    // Head fields read as zero while the queue is empty.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= dec;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            halt_seen <= 1'b0;
            halt_q    <= 1'b0;
            retired_q <= '0;
        end else if (bus.flush) begin
            // Drops any speculative HALT still in the queue; a retired
            // HALT (halt_q) survives.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            halt_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (dec.is_halt) halt_seen <= 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                retired_q <= retired_q + 1'b1;
                if (head.is_halt) halt_q <= 1'b1;
            end
        end
    end

    assign bus.out_pc       = head.pc;
    assign bus.out_rs       = head.rs;
    assign bus.out_rt       = head.rt;
    assign bus.out_wsel     = head.wsel;
    assign bus.out_shamt    = head.shamt;
    assign bus.out_imm      = head.imm;
    assign bus.out_aluctr   = head.aluctr;
    assign bus.out_alusrc   = head.alusrc;
    assign bus.out_regwr    = head.regwr;
    assign bus.out_memtoreg = head.memtoreg;
    assign bus.out_dren     = head.dren;
    assign bus.out_dwen     = head.dwen;
    assign bus.out_atomic   = head.atomic;
    assign bus.out_pcsrc    = head.pcsrc;
    assign bus.out_halt     = head.is_halt;
    assign bus.halt         = halt_q;
    assign bus.retired      = retired_q;
endmodule

// File: tb/tb_decode_queue_unit.sv
// Directed bench for decode_queue_unit: a default build (DEPTH=4, CNT_W=32)
// and a CNT_W=4 build for counter wrap, sharing clock and reset.
module tb_decode_queue_unit;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_ret = 0;

    decode_queue_unit_if #(.ADDR_W(32), .CNT_W(32)) aif ();
    decode_queue_unit_if #(.ADDR_W(32), .CNT_W(4))  bif ();

    decode_queue_unit #(.DEPTH(4), .ADDR_W(32), .CNT_W(32)) dut_a (
        .CLK(CLK), .RST(RST), .bus(aif));
    decode_queue_unit #(.DEPTH(4), .ADDR_W(32), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .bus(bif));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [19:0] ctl_a();
        return {aif.out_regwr, aif.out_memtoreg, aif.out_dren, aif.out_dwen,
                aif.out_atomic, aif.out_pcsrc, aif.out_aluctr, aif.out_alusrc,
                aif.out_wsel};
    endfunction

    // decode vectors: {regwr,memtoreg,dren,dwen,atomic,pcsrc,aluctr,alusrc,wsel}
    logic [31:0] dv_in  [9];
    logic [19:0] dv_exp [9];

    initial begin
        dv_in[0] = 32'h8C220004; dv_exp[0] = {1'b1,2'd1,1'b1,1'b0,1'b0,2'd0,4'd2,2'd1,5'd2};  // LW
        dv_in[1] = 32'hAC220004; dv_exp[1] = {1'b0,2'd0,1'b0,1'b1,1'b0,2'd0,4'd2,2'd1,5'd2};  // SW
        dv_in[2] = 32'h0C000010; dv_exp[2] = {1'b1,2'd2,1'b0,1'b0,1'b0,2'd2,4'd2,2'd0,5'd31}; // JAL
        dv_in[3] = 32'h10220003; dv_exp[3] = {1'b0,2'd0,1'b0,1'b0,1'b0,2'd3,4'd3,2'd0,5'd2};  // BEQ
        dv_in[4] = 32'h00000000; dv_exp[4] = {1'b0,2'd0,1'b0,1'b0,1'b0,2'd0,4'd0,2'd0,5'd0};  // NOP
        dv_in[5] = 32'hE0220000; dv_exp[5] = {1'b1,2'd1,1'b0,1'b1,1'b1,2'd0,4'd2,2'd1,5'd2};  // SC
        dv_in[6] = 32'h03E00008; dv_exp[6] = {1'b0,2'd0,1'b0,1'b0,1'b0,2'd1,4'd2,2'd0,5'd0};  // JR $31
        dv_in[7] = 32'h50220000; dv_exp[7] = {1'b0,2'd0,1'b0,1'b0,1'b0,2'd0,4'd2,2'd0,5'd2};  // unknown op
        dv_in[8] = 32'h00221823; dv_exp[8] = {1'b1,2'd0,1'b0,1'b0,1'b0,2'd0,4'd3,2'd0,5'd3};  // SUBU

        aif.in_valid = 0; aif.instr = 0; aif.pc = 0; aif.flush = 0; aif.out_ready = 0;
        bif.in_valid = 0; bif.instr = 0; bif.pc = 0; bif.flush = 0; bif.out_ready = 0;

        // reset
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        check("rst_out_valid", aif.out_valid, 0);
        check("rst_in_ready", aif.in_ready, 1);
        check("rst_halt", aif.halt, 0);
        check("rst_retired", aif.retired, 0);
        check("rst_fields_zero", {aif.out_wsel, aif.out_imm, aif.out_pc}, 0);

        // 1: ADDU $3,$1,$2
        aif.in_valid = 1; aif.instr = 32'h00221821; aif.pc = 32'h100;
        #1;
        check("no_comb_path", aif.out_valid, 0);
        tick();
        aif.in_valid = 0;
        check("addu_valid", aif.out_valid, 1);
        check("addu_wsel", aif.out_wsel, 3);
        check("addu_aluctr", aif.out_aluctr, 2);
        check("addu_regwr", aif.out_regwr, 1);
        check("addu_pc_rs_rt", {aif.out_pc, aif.out_rs, aif.out_rt}, {32'h100, 5'd1, 5'd2});
        aif.out_ready = 1; tick(); aif.out_ready = 0; exp_ret++;
        check("addu_popped", aif.out_valid, 0);
        check("addu_retired", aif.retired, exp_ret);

        // 2: fill to DEPTH, back-pressure, pop frees a slot one cycle later
        for (int i = 0; i < 4; i++) begin
            aif.in_valid = 1; aif.instr = 32'h2405FFF0 | i; aif.pc = 32'h200 + 4*i;
            tick();
            check($sformatf("fill_ready_%0d", i), aif.in_ready, (i < 3) ? 1 : 0);
        end
        aif.instr = 32'h2405FFF4; aif.pc = 32'h210;
        tick();
        check("fifth_held", aif.in_ready, 0);
        check("head_pc0", aif.out_pc, 32'h200);
        check("addiu_imm_sext", {aif.out_imm, aif.out_alusrc, aif.out_wsel}, {32'hFFFFFFF0, 2'd1, 5'd5});
        aif.out_ready = 1; tick(); aif.out_ready = 0; exp_ret++;
        check("ready_after_pop", aif.in_ready, 1);
        check("retired_after_pop", aif.retired, exp_ret);
        tick();
        aif.in_valid = 0;
        check("full_again", aif.in_ready, 0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("drain_pc_%0d", i), aif.out_pc, 32'h200 + 4*i);
            aif.out_ready = 1; tick(); aif.out_ready = 0; exp_ret++;
        end
        check("drained", aif.out_valid, 0);
        check("drain_retired", aif.retired, exp_ret);

        // 3: LUI then ORI
        aif.in_valid = 1; aif.instr = 32'h3C011234; aif.pc = 32'h300; tick();
        aif.instr = 32'h34218000; aif.pc = 32'h304; tick();
        aif.in_valid = 0;
        check("lui_imm", {aif.out_imm, aif.out_alusrc}, {32'h12340000, 2'd2});
        aif.out_ready = 1; tick(); aif.out_ready = 0; exp_ret++;
        check("ori_imm", {aif.out_imm, aif.out_alusrc, aif.out_aluctr}, {32'h00008000, 2'd1, 4'd5});
        aif.out_ready = 1; tick(); aif.out_ready = 0; exp_ret++;

        // decode table
        for (int i = 0; i < 9; i++) begin
            aif.in_valid = 1; aif.instr = dv_in[i]; aif.pc = 32'h400 + 4*i; tick();
            aif.in_valid = 0;
            check($sformatf("decode_%0d", i), ctl_a(), dv_exp[i]);
            aif.out_ready = 1; tick(); aif.out_ready = 0; exp_ret++;
        end
        check("decode_retired", aif.retired, exp_ret);

        // 4: HALT blocks intake, sets halt on retire, halt sticky across flush
        aif.in_valid = 1; aif.instr = 32'hFC000000; aif.pc = 32'h500; tick();
        aif.instr = 32'h00221821; aif.pc = 32'h504;
        check("halt_blocks", aif.in_ready, 0);
        check("halt_head", {aif.out_halt, aif.halt}, 2'b10);
        tick();
        check("halt_still_blocked", aif.in_ready, 0);
        aif.out_ready = 1; tick(); aif.out_ready = 0; aif.in_valid = 0; exp_ret++;
        check("halt_set", aif.halt, 1);
        check("halt_queue_empty", aif.out_valid, 0);
        check("halt_retired", aif.retired, exp_ret);
        aif.flush = 1; tick(); aif.flush = 0;
        check("halt_sticky_flush", aif.halt, 1);
        check("flush_clears_seen", aif.in_ready, 1);
        RST = 1; tick(); RST = 0; exp_ret = 0;
        check("halt_cleared_rst", {aif.halt, aif.retired}, 0);

        // 5: flush with queued speculative HALT
        aif.in_valid = 1;
        aif.instr = 32'h00221821; aif.pc = 32'h600; tick();
        aif.instr = 32'h00221823; aif.pc = 32'h604; tick();
        aif.instr = 32'hFC000000; aif.pc = 32'h608; tick();
        aif.instr = 32'h00221821; aif.pc = 32'h60C;
        check("three_queued_blocked", aif.in_ready, 0);
        aif.flush = 1; aif.out_ready = 1; tick();
        aif.flush = 0; aif.out_ready = 0; aif.in_valid = 0;
        check("flush_empty", aif.out_valid, 0);
        check("flush_retired", aif.retired, exp_ret);
        check("flush_ready", aif.in_ready, 1);
        check("flush_halt", aif.halt, 0);
        check("flush_fields", aif.out_wsel, 0);
        aif.in_valid = 1; aif.instr = 32'h00221821; aif.pc = 32'h700; tick();
        aif.in_valid = 0;
        check("post_flush_push", aif.out_pc, 32'h700);

        // 6: CNT_W=4 wrap, then RST during a push
        for (int i = 0; i < 15; i++) begin
            bif.in_valid = 1; bif.instr = 32'h24050001; bif.pc = 32'h800 + 4*i; tick();
            bif.in_valid = 0; bif.out_ready = 1; tick(); bif.out_ready = 0;
        end
        check("b_retired_max", bif.retired, 4'hF);
        bif.in_valid = 1; tick(); bif.in_valid = 0;
        bif.out_ready = 1; tick(); bif.out_ready = 0;
        check("b_retired_wrap", bif.retired, 0);
        bif.in_valid = 1; tick(); bif.in_valid = 0;
        bif.out_ready = 1; tick(); bif.out_ready = 0;
        bif.in_valid = 1; tick();
        check("b_nonempty", {bif.out_valid, bif.retired}, {1'b1, 4'd1});
        RST = 1; tick(); RST = 0; bif.in_valid = 0;
        check("b_rst_empty", bif.out_valid, 0);
        check("b_rst_ready", bif.in_ready, 1);
        check("b_rst_retired", bif.retired, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
